// File: rtl/wallace_pkg.sv
// wallace_pkg: default sizes and row-count helpers for the Wallace tree multiplier
package wallace_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_TAG_W = 4;
  function automatic int rows_after(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction
  function automatic int rows_at(input int n, input int lvl);
    int r;
    r = n;
    for (int i = 0; i < lvl; i++) r = rows_after(r);
    return r;
  endfunction
  function automatic int csa_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    for (int i = 0; i < 64; i++)
      if (r > 2) begin
        r = rows_after(r);
        l++;
      end
    return l;
  endfunction
endpackage

// File: rtl/csa_row.sv
// csa_row: one row of 3:2 compressors; the carry out of the top bit is discarded
module csa_row #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);
  always_comb begin
    sum = a ^ b ^ c;
    carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};
  end
endmodule

// File: rtl/wallace_mul_pipe.sv
// wallace_mul_pipe: pipelined signed/unsigned Wallace tree multiplier with tag sideband
module wallace_mul_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);
  localparam int L = csa_levels(WIDTH);
  localparam int P = 2 * WIDTH;
  localparam int S = L + 2;
  logic en;
  logic [P-1:0] a_ext;
  logic [P-1:0] pp [WIDTH];
  logic [P-1:0] row_q [0:L][WIDTH];
  logic [P-1:0] lvl_d [1:L][WIDTH];
  logic [P-1:0] prod_d, prod_q;
  logic [S-1:0] valid_d, valid_q;
  logic [TAG_W-1:0] tag_q [S];
  // Signed mode negates the top row, since the multiplier MSB carries weight -2^(WIDTH-1)
  always_comb begin
    en = !valid_q[S-1] || out_ready;
    a_ext = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
    for (int i = 0; i < WIDTH; i++) pp[i] = in_b[i] ? a_ext << i : '0;
    pp[WIDTH-1] = in_signed ? -pp[WIDTH-1] : pp[WIDTH-1];
    valid_d = {valid_q[S-2:0], in_valid};
    prod_d = row_q[L][0] + row_q[L][1];
  end
  for (genvar l = 1; l <= L; l++) begin : g_lvl
    localparam int N = rows_at(WIDTH, l - 1);
    localparam int G = N / 3;
    for (genvar g = 0; g < G; g++) begin : g_csa
      csa_row #(.W(P)) u_csa (
        .a(row_q[l-1][3*g]),
        .b(row_q[l-1][3*g+1]),
        .c(row_q[l-1][3*g+2]),
        .sum(lvl_d[l][2*g]),
        .carry(lvl_d[l][2*g+1])
      );
    end
    for (genvar j = 2 * G; j < WIDTH; j++) begin : g_rest
      if (j < 2 * G + N % 3) begin : g_pass
        assign lvl_d[l][j] = row_q[l-1][G+j];
      end else begin : g_zero
        assign lvl_d[l][j] = '0;
      end
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      valid_q <= '0;
      prod_q <= '0;
      for (int i = 0; i < S; i++) tag_q[i] <= '0;
      for (int k = 0; k <= L; k++)
        for (int j = 0; j < WIDTH; j++) row_q[k][j] <= '0;
    end else if (en) begin
      valid_q <= valid_d;
      prod_q <= prod_d;
      tag_q[0] <= in_tag;
      for (int i = 1; i < S; i++) tag_q[i] <= tag_q[i-1];
      for (int j = 0; j < WIDTH; j++) row_q[0][j] <= pp[j];
      for (int k = 1; k <= L; k++)
        for (int j = 0; j < WIDTH; j++) row_q[k][j] <= lvl_d[k][j];
    end
  assign in_ready = en;
  assign out_valid = valid_q[S-1];
  assign busy = |valid_q;
  assign out_product = prod_q;
  assign out_tag = tag_q[S-1];
endmodule

// File: tb/tb_wallace_mul_pipe.sv
// tb_wallace_mul_pipe: scoreboard bench with directed and random traffic for the 32-bit multiplier
module tb_wallace_mul_pipe;
  localparam int W = 32;
  localparam int TW = 4;
  localparam int L = 8;
  typedef struct packed {
    logic [63:0] p;
    logic [3:0]  t;
  } exp_t;
  logic clock = 0;
  logic reset = 1;
  logic in_valid = 0;
  logic in_signed = 0;
  logic out_ready = 1;
  logic [W-1:0] in_a = 0;
  logic [W-1:0] in_b = 0;
  logic [TW-1:0] in_tag = 0;
  logic in_ready, out_valid, busy;
  logic [2*W-1:0] out_product;
  logic [TW-1:0] out_tag;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic hold = 0;
  logic [63:0] hold_p;
  logic [3:0] hold_t;

  always #5 clock = ~clock;

  wallace_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_signed(in_signed),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_product(out_product),
    .out_tag(out_tag),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return x * y;
  endfunction

  function automatic logic [31:0] rnd_op();
    int k;
    k = $urandom_range(0, 5);
    return k == 0 ? 32'h0 : k == 1 ? 32'hFFFFFFFF : k == 2 ? 32'h80000000 : k == 3 ? 32'h1 : $urandom;
  endfunction

  // Monitor: checks handshake invariants, output stability under stall, and scoreboard order
  initial forever begin
    @(negedge clock);
    if (reset) begin
      exp_q.delete();
      hold = 0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      chk("busy", busy, exp_q.size() != 0);
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_product", out_product, hold_p);
        chk("hold_tag", out_tag, hold_t);
      end
      hold = out_valid && !out_ready;
      hold_p = out_product;
      hold_t = out_tag;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_output", out_valid, 0);
        else begin
          cur = exp_q.pop_front();
          chk("product", out_product, cur.p);
          chk("tag", out_tag, cur.t);
        end
      end
      if (in_valid && in_ready) begin
        cur.p = ref_mul(in_a, in_b, in_signed);
        cur.t = in_tag;
        exp_q.push_back(cur);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] t);
    in_valid = 1;
    in_a = a;
    in_b = b;
    in_signed = s;
    in_tag = t;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) step(1);
    chk("idle", busy, 0);
  endtask

  task automatic lat(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] t,
                     input logic [63:0] expv);
    wait_idle();
    put(a, b, s, t);
    step(1);
    in_valid = 0;
    step(L);
    chk("lat_early", out_valid, 0);
    step(1);
    chk("lat_valid", out_valid, 1);
    chk("lat_product", out_product, expv);
    chk("lat_tag", out_tag, t);
  endtask

  initial begin
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_product", out_product, 0);
    chk("rst_tag", out_tag, 0);
    step(2);
    reset = 0;
    lat(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 5, 64'hFFFFFFFE00000001);
    lat(32'h80000000, 32'hFFFFFFFF, 1, 6, 64'h0000000080000000);
    lat(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 7, 64'h1);
    lat(32'h80000000, 32'h80000000, 1, 8, 64'h4000000000000000);
    lat(32'h00000000, 32'h12345678, 1, 9, 64'h0);
    // Back-to-back results on consecutive cycles
    wait_idle();
    put(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1);
    step(1);
    put(32'd3, 32'd7, 0, 2);
    step(1);
    put(32'h80000000, 32'h80000000, 1, 3);
    step(1);
    in_valid = 0;
    step(L - 1);
    chk("b2b_p1", out_product, 64'hFFFFFFFE00000001);
    step(1);
    chk("b2b_p2", out_product, 64'd21);
    step(1);
    chk("b2b_p3", out_product, 64'h4000000000000000);
    chk("b2b_t3", out_tag, 3);
    // Backpressure with a full pipeline
    wait_idle();
    for (int i = 0; i < 12; i++) begin
      put($urandom, $urandom, 1'($urandom), 4'(i));
      step(1);
    end
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      put($urandom, $urandom, 1'($urandom), 4'hF);
      #1;
      chk("bp_in_ready", in_ready, 0);
      step(1);
    end
    in_valid = 0;
    out_ready = 1;
    wait_idle();
    // Reset with four operations in flight
    for (int i = 0; i < 4; i++) begin
      put($urandom, $urandom, 1'($urandom), 4'(10 + i));
      step(1);
    end
    in_valid = 0;
    step(2);
    #2;
    reset = 1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_product", out_product, 0);
    chk("mid_rst_tag", out_tag, 0);
    step(1);
    reset = 0;
    lat(32'h00012345, 32'hFFFF0000, 1, 4, ref_mul(32'h00012345, 32'hFFFF0000, 1));
    // Random traffic and backpressure
    for (int i = 0; i < 4000; i++) begin
      put(rnd_op(), rnd_op(), 1'($urandom), 4'($urandom));
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      step(1);
    end
    in_valid = 0;
    out_ready = 1;
    wait_idle();
    step(1);
    chk("drain_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
